// File: rtl/jtcommando_dwnld.sv
// ROM download splitter: bytes below PROM_START are buffered and written to SDRAM,
// bytes at/above go straight to PROMs. Optional checksum port: JTCOMMANDO_DWNLD_CHKSUM_EN.
module jtcommando_dwnld #(
  parameter logic [21:0] PROM_START = 22'h3C000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        ioctl_wr,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        prog_we,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  input  logic        sdram_ack,
  output logic        prom_we,
  output logic [9:0]  prom_addr,
  output logic [3:0]  prom_data,
  output logic        dwnld_done,
  output logic        overflow
`ifdef JTCOMMANDO_DWNLD_CHKSUM_EN
  ,
  output logic [15:0] chksum
`endif
);

  localparam int PW = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        r_state;
  logic [29:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_dl_prev;
  logic          r_prog_we, r_prom_we, r_done, r_overflow;
  logic [21:0]   r_prog_addr;
  logic [7:0]    r_prog_data;
  logic [1:0]    r_prog_mask;
  logic [9:0]    r_prom_addr;
  logic [3:0]    r_prom_data;

  logic          w_wr_ok, w_low, w_to_sdram, w_to_prom, w_pop, w_push, w_drop;
  logic          w_load, w_we_next, w_fall, w_rise, w_draining, w_finish;
  logic [CW-1:0] w_count_after_pop, w_count_next;
  logic [PW-1:0] w_rd_next;
  logic [29:0]   w_head_next;

  assign w_wr_ok    = ioctl_wr & downloading;
  assign w_low      = ioctl_addr < PROM_START;
  assign w_to_sdram = w_wr_ok & w_low;
  assign w_to_prom  = w_wr_ok & ~w_low;

  // Fullness is judged after this cycle's pop so a push+ack pair never drops
  assign w_pop             = r_prog_we & sdram_ack;
  assign w_count_after_pop = r_count - CW'(w_pop);
  assign w_push            = w_to_sdram & (w_count_after_pop < CW'(FIFO_DEPTH));
  assign w_drop            = w_to_sdram & ~w_push;
  assign w_count_next      = w_count_after_pop + CW'(w_push);
  assign w_rd_next         = r_rd_ptr + PW'(1);

  // After an ack the next word is either the following entry or the byte arriving now
  always_comb begin
    w_head_next = r_mem[r_rd_ptr];
    if (r_prog_we)
      w_head_next = (r_count > CW'(1)) ? r_mem[w_rd_next] : {ioctl_addr, ioctl_data};
  end

  assign w_load     = r_prog_we ? (w_pop & (w_count_next != '0)) : (r_count != '0);
  assign w_we_next  = r_prog_we ? (~w_pop | (w_count_next != '0)) : (r_count != '0);
  assign w_fall     = r_dl_prev & ~downloading;
  assign w_rise     = ~r_dl_prev & downloading;
  assign w_draining = w_fall | (r_state == DRAIN);
  assign w_finish   = w_draining & ~w_we_next & (w_count_next == '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {ioctl_addr, ioctl_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dl_prev   <= 1'b0;
      r_prog_we   <= 1'b0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_mask <= 2'b11;
      r_prom_we   <= 1'b0;
      r_prom_addr <= '0;
      r_prom_data <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_dl_prev <= downloading;
      r_count   <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      if (w_drop) r_overflow <= 1'b1;

      r_prog_we <= w_we_next;
      if (w_load) begin
        r_prog_addr <= {1'b0, w_head_next[29:9]};
        r_prog_data <= w_head_next[7:0];
        r_prog_mask <= w_head_next[8] ? 2'b01 : 2'b10;
      end

      r_prom_we <= w_to_prom;
      if (w_to_prom) begin
        r_prom_addr <= ioctl_addr[9:0] - PROM_START[9:0];
        r_prom_data <= ioctl_data[3:0];
      end

      // DRAIN keeps servicing the buffer; only an empty buffer ends it
      if (w_draining) begin
        r_state <= w_finish ? IDLE : DRAIN;
        r_done  <= w_finish;
      end else begin
        r_state <= w_we_next ? REQ : IDLE;
        r_done  <= 1'b0;
      end
    end
  end

  assign prog_we    = r_prog_we;
  assign prog_addr  = r_prog_addr;
  assign prog_data  = r_prog_data;
  assign prog_mask  = r_prog_mask;
  assign prom_we    = r_prom_we;
  assign prom_addr  = r_prom_addr;
  assign prom_data  = r_prom_data;
  assign dwnld_done = r_done;
  assign overflow   = r_overflow;

`ifdef JTCOMMANDO_DWNLD_CHKSUM_EN
  logic [15:0] r_chksum;
  logic        r_frozen;
  logic        w_accept;

  assign w_accept = w_push | w_to_prom;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chksum <= '0;
      r_frozen <= 1'b0;
    end else begin
      if (w_rise) begin
        r_chksum <= w_accept ? {8'h00, ioctl_data} : 16'h0000;
        r_frozen <= 1'b0;
      end else if (w_accept && !r_frozen) begin
        r_chksum <= r_chksum + {8'h00, ioctl_data};
      end
      if (w_finish) r_frozen <= 1'b1;
    end
  end

  assign chksum = r_chksum;
`endif

endmodule

// File: tb/tb_jtcommando_dwnld.sv
// Randomized bench for jtcommando_dwnld with a queue-based reference model and directed cases.
module tb_jtcommando_dwnld;
  localparam logic [21:0] PS = 22'h3C000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        sdram_ack = 1'b0;
  logic        prog_we, prom_we, dwnld_done, overflow;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [9:0]  prom_addr;
  logic [3:0]  prom_data;
`ifdef JTCOMMANDO_DWNLD_CHKSUM_EN
  logic [15:0] chksum;
`endif

  jtcommando_dwnld #(.PROM_START(PS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .sdram_ack(sdram_ack), .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .dwnld_done(dwnld_done), .overflow(overflow)
`ifdef JTCOMMANDO_DWNLD_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: pending SDRAM bytes as a queue, head is what must be presented
  typedef struct packed { logic [21:0] a; logic [7:0] d; } ent_t;
  ent_t        mq[$];
  bit          exp_we, exp_ovf, exp_done, exp_prom_we, draining, dl_prev, m_frozen;
  logic [9:0]  exp_prom_addr;
  logic [3:0]  exp_prom_data;
  logic [15:0] m_sum;

  always @(posedge clk or negedge rst_n) begin
    int pre;
    bit pop, wok, fall, rise, acc;
    logic [21:0] off;
    if (!rst_n) begin
      mq.delete();
      exp_we = 0; exp_ovf = 0; exp_done = 0; exp_prom_we = 0;
      exp_prom_addr = '0; exp_prom_data = '0;
      draining = 0; dl_prev = 0; m_sum = '0; m_frozen = 0;
    end else begin
      pre  = mq.size();
      wok  = ioctl_wr && downloading;
      fall = dl_prev && !downloading;
      rise = !dl_prev && downloading;
      dl_prev = downloading;
      pop = exp_we && sdram_ack;
      if (pop) void'(mq.pop_front());
      acc = 0;
      if (wok && ioctl_addr < PS) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({ioctl_addr, ioctl_data});
          acc = 1;
        end else exp_ovf = 1;
      end
      exp_prom_we = wok && (ioctl_addr >= PS);
      if (exp_prom_we) begin
        acc = 1;
        off = ioctl_addr - PS;
        exp_prom_addr = off[9:0];
        exp_prom_data = ioctl_data[3:0];
      end
      if (exp_we) exp_we = pop ? (mq.size() > 0) : 1'b1;
      else        exp_we = (pre > 0);
      if (fall) draining = 1;
      exp_done = 0;
      if (draining && mq.size() == 0) begin
        exp_done = 1;
        draining = 0;
      end
      if (rise) begin m_sum = '0; m_frozen = 0; end
      if (acc && !m_frozen) m_sum = m_sum + {8'h00, ioctl_data};
      if (exp_done) m_frozen = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("prog_we", {31'd0, prog_we}, {31'd0, exp_we});
      if (exp_we && mq.size() > 0) begin
        chk("prog_addr", {10'd0, prog_addr}, {11'd0, mq[0].a[21:1]});
        chk("prog_data", {24'd0, prog_data}, {24'd0, mq[0].d});
        chk("prog_mask", {30'd0, prog_mask}, mq[0].a[0] ? 32'd1 : 32'd2);
      end
      chk("prom_we", {31'd0, prom_we}, {31'd0, exp_prom_we});
      chk("prom_addr", {22'd0, prom_addr}, {22'd0, exp_prom_addr});
      chk("prom_data", {28'd0, prom_data}, {28'd0, exp_prom_data});
      chk("dwnld_done", {31'd0, dwnld_done}, {31'd0, exp_done});
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
`ifdef JTCOMMANDO_DWNLD_CHKSUM_EN
      chk("chksum", {16'd0, chksum}, {16'd0, m_sum});
`endif
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},   {31'd0, prog_we}, 0);
    chk({tag, "_addr"}, {10'd0, prog_addr}, 0);
    chk({tag, "_data"}, {24'd0, prog_data}, 0);
    chk({tag, "_mask"}, {30'd0, prog_mask}, 3);
    chk({tag, "_pwe"},  {31'd0, prom_we}, 0);
    chk({tag, "_padr"}, {22'd0, prom_addr}, 0);
    chk({tag, "_pdat"}, {28'd0, prom_data}, 0);
    chk({tag, "_done"}, {31'd0, dwnld_done}, 0);
    chk({tag, "_ovf"},  {31'd0, overflow}, 0);
  endtask

  task automatic wr_byte(input logic [21:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  initial begin
    bit seen;
    repeat (3) step();
    chk_reset_vals("rst0");
    rst_n = 1'b1;
    chk_en = 1'b1;
    downloading = 1'b1;
    step();

    // Even SDRAM byte held until acked three cycles into the request
    wr_byte(22'h00004, 8'h12);
    chk("d1_we_before", {31'd0, prog_we}, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("d1_we", {31'd0, prog_we}, 1);
      chk("d1_addr", {10'd0, prog_addr}, 32'h2);
      chk("d1_mask", {30'd0, prog_mask}, 2);
      chk("d1_data", {24'd0, prog_data}, 32'h12);
      if (i == 2) sdram_ack = 1'b1;
      step();
    end
    sdram_ack = 1'b0;
    chk("d1_we_fall", {31'd0, prog_we}, 0);
    $display("[TB] d1 sdram byte 0x12 @0x00004 done");

    // PROM byte bypasses the buffer
    wr_byte(22'h3C007, 8'hA5);
    chk("d2_pwe", {31'd0, prom_we}, 1);
    chk("d2_padr", {22'd0, prom_addr}, 32'h7);
    chk("d2_pdat", {28'd0, prom_data}, 32'h5);
    chk("d2_we", {31'd0, prog_we}, 0);
    step();
    chk("d2_pwe_fall", {31'd0, prom_we}, 0);
    chk("d2_we2", {31'd0, prog_we}, 0);
    $display("[TB] d2 prom byte 0xA5 @0x3C007 done");

    // Overflow with no acks, then two acks drain in order
    wr_byte(22'h00010, 8'h11);
    wr_byte(22'h00011, 8'h22);
    wr_byte(22'h00012, 8'h33);
    chk("d3_ovf", {31'd0, overflow}, 1);
    chk("d3_we", {31'd0, prog_we}, 1);
    chk("d3_data1", {24'd0, prog_data}, 32'h11);
    chk("d3_mask1", {30'd0, prog_mask}, 2);
    sdram_ack = 1'b1;
    step();
    chk("d3_data2", {24'd0, prog_data}, 32'h22);
    chk("d3_mask2", {30'd0, prog_mask}, 1);
    chk("d3_addr2", {10'd0, prog_addr}, 32'h8);
    step();
    sdram_ack = 1'b0;
    chk("d3_we_fall", {31'd0, prog_we}, 0);
    $display("[TB] d3 overflow/order done");

    // Download ends before the ack: done follows the ack cycle
    wr_byte(22'h00020, 8'h5A);
    step();
    downloading = 1'b0;
    step();
    chk("d4_done_a", {31'd0, dwnld_done}, 0);
    step();
    chk("d4_done_b", {31'd0, dwnld_done}, 0);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk("d4_done", {31'd0, dwnld_done}, 1);
    chk("d4_we", {31'd0, prog_we}, 0);
    step();
    chk("d4_done_fall", {31'd0, dwnld_done}, 0);
    $display("[TB] d4 dwnld_done timing done");

    // Reset while a request is pending with two entries buffered
    downloading = 1'b1;
    step();
    wr_byte(22'h00030, 8'h44);
    wr_byte(22'h00031, 8'h55);
    chk("d5_we", {31'd0, prog_we}, 1);
    rst_n = 1'b0;
    downloading = 1'b0;
    #1;
    chk_reset_vals("d5");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("d5_no_done", {31'd0, dwnld_done}, 0);
      chk("d5_no_we", {31'd0, prog_we}, 0);
    end
    $display("[TB] d5 reset mid-request done");

    // Randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      if ((c % 300) == 0)  downloading = 1'b1;
      if ((c % 300) == 250) downloading = 1'b0;
      ioctl_wr = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 99) < 70)
        ioctl_addr = 22'($urandom_range(32'(PS) - 1, 0));
      else
        ioctl_addr = 22'($urandom_range(32'h3FFFFF, 32'(PS)));
      ioctl_data = 8'($urandom);
      sdram_ack = ($urandom_range(0, 99) < 40);
      step();
    end
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    sdram_ack = 1'b1;
    repeat (10) step();
    $display("[TB] random phase done");

`ifdef JTCOMMANDO_DWNLD_CHKSUM_EN
    downloading = 1'b1;
    step();
    wr_byte(22'h00000, 8'hFF);
    wr_byte(22'h00001, 8'hFF);
    wr_byte(22'h3C000, 8'h03);
    downloading = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (dwnld_done) begin
        seen = 1'b1;
        chk("cs_value", {16'd0, chksum}, 32'h0201);
      end
    end
    chk("cs_done_seen", {31'd0, seen}, 1);
    $display("[TB] checksum case done");
`else
    seen = 1'b0;
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
